// File: rtl/mult_hilo_unit_pkg.sv
// mult_hilo_unit_pkg: shared state encoding, MULT/MULTU funct codes and default operand width
package mult_hilo_unit_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [5:0] FUNCT_MULT = 6'd24;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;
endpackage

// File: rtl/mult_hilo_unit_if.sv
// mult_hilo_unit_if: multiplier bus; master drives start/is_signed/op_a/op_b/hi_we/lo_we/wdata, slave returns busy/done/hi/lo
interface mult_hilo_unit_if
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (
    output start, is_signed, op_a, op_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );
  modport slave (
    input  start, is_signed, op_a, op_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_hilo_unit_shift_add_step.sv
// mult_shift_add_step: one shift-add iteration; i_acc/i_mcand/i_mplier in, o_acc/o_mplier out
module mult_shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0]   o_mplier
);
  logic [WIDTH:0] w_sum;
  // carry out of the upper-half add becomes the new MSB after the shift
  assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_mplier[0] ? {1'b0, i_mcand} : '0);
  assign o_acc    = {w_sum, i_acc[WIDTH-1:1]};
  assign o_mplier = i_mplier >> 1;
endmodule

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: sequential MULT/MULTU owning HI/LO; ports clk, rst (async high), bus (slave side of mult_hilo_unit_if)
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input logic             clk,
  input logic             rst,
  mult_hilo_unit_if.slave bus
);
  state_t             r_state, w_state_nxt;
  logic [2*WIDTH-1:0] r_acc, w_acc_nxt, w_prod;
  logic [WIDTH-1:0]   r_mcand, r_mplier, w_mplier_nxt, r_hi, r_lo, w_a_mag, w_b_mag;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg, r_done, w_idle, w_start, w_last;
  assign w_idle  = r_state == IDLE;
  assign w_start = w_idle & bus.start;
  assign w_last  = r_cnt == CNT_W'(WIDTH - 1);
  // negating the most negative value wraps to itself, which is its correct unsigned magnitude
  assign w_a_mag = (bus.is_signed & bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign w_b_mag = (bus.is_signed & bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  assign w_prod  = r_neg ? -r_acc : r_acc;
  mult_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_mplier(r_mplier),
    .o_acc   (w_acc_nxt),
    .o_mplier(w_mplier_nxt)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_start ? RUN : (r_state == RUN && w_last) ? FIX : (r_state == FIX) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= r_state == FIX;
      if (w_start) begin
        r_neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
        r_mcand  <= w_a_mag;
        r_mplier <= w_b_mag;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == RUN) begin
        r_acc    <= w_acc_nxt;
        r_mplier <= w_mplier_nxt;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (r_state == FIX) begin
        {r_hi, r_lo} <= w_prod;
      end else if (w_idle) begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end
    end
  end
  assign bus.busy = !w_idle;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit: randomized self-checking bench for mult_hilo_unit against an arithmetic product model
module tb_mult_hilo_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  mult_hilo_unit_if #(.WIDTH(32)) bus ();
  mult_hilo_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'({32'b0, a});
    pb = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(pa * pb);
  endfunction
  // ev_kind: 0 none, 1 extra start with other operands, 2 hi_we pulse; both driven at negedge ev_k
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic s, input logic lo_we0,
                          input int ev_k, input int ev_kind,
                          output int lat, output int busy_n, output int done_n, output logic hold_ok);
    logic [31:0] h0, l0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = s; bus.op_a = a; bus.op_b = b;
    bus.lo_we = lo_we0; bus.wdata = 32'h5555_AAAA;
    lat = -1; busy_n = 0; done_n = 0; hold_ok = 1'b1; h0 = '0; l0 = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.lo_we = 1'b0;
      bus.start = (ev_kind == 1 && k == ev_k);
      if (bus.start) begin bus.op_a = 32'd100; bus.op_b = 32'd100; bus.is_signed = 1'b0; end
      bus.hi_we = (ev_kind == 2 && k == ev_k);
      bus.wdata = 32'hDEAD_BEEF;
      if (k == 0) begin h0 = bus.hi; l0 = bus.lo; end
      else if (bus.busy && (bus.hi !== h0 || bus.lo !== l0)) hold_ok = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin done_n++; if (lat < 0) lat = k; end
    end
    bus.start = 1'b0; bus.hi_we = 1'b0;
  endtask
  task automatic chk_mult(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
    int lat, bn, dn; logic hold; logic [63:0] exp;
    exp = model(a, b, s);
    run_mult(a, b, s, 1'b0, 0, 0, lat, bn, dn, hold);
    checks++; if ({bus.hi, bus.lo} !== exp) begin errors++; $display("FAIL %s hilo got=%h exp=%h", name, {bus.hi, bus.lo}, exp); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL %s latency got=%0d exp=33", name, lat); end
    checks++; if (bn !== 33) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=33", name, bn); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL %s done_pulses got=%0d exp=1", name, dn); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL %s hilo_hold got=%b exp=1", name, hold); end
  endtask
  task automatic test_reset();
    bus.start = 0; bus.is_signed = 0; bus.op_a = 0; bus.op_b = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    rst = 1'b0;
  endtask
  task automatic test_multu_basic();
    chk_mult("multu_3x5", 32'd3, 32'd5, 1'b0);
    chk_mult("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
  endtask
  task automatic test_mult_signed();
    chk_mult("mult_m2x7", 32'hFFFF_FFFE, 32'd7, 1'b1);
    chk_mult("mult_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1);
    chk_mult("mult_min_x1", 32'h8000_0000, 32'd1, 1'b1);
  endtask
  task automatic test_random();
    for (int i = 0; i < 8; i++) chk_mult("rand", $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask
  task automatic test_start_while_busy();
    int lat, bn, dn; logic hold;
    run_mult(32'd6, 32'd7, 1'b0, 1'b0, 9, 1, lat, bn, dn, hold);
    checks++; if ({bus.hi, bus.lo} !== model(32'd6, 32'd7, 1'b0)) begin errors++; $display("FAIL busy_start hilo got=%h exp=%h", {bus.hi, bus.lo}, model(32'd6, 32'd7, 1'b0)); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL busy_start done_pulses got=%0d exp=1", dn); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start latency got=%0d exp=33", lat); end
  endtask
  task automatic test_mthi_mtlo();
    int lat, bn, dn; logic hold; logic [31:0] a, b; logic [63:0] exp;
    @(negedge clk); bus.lo_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk); bus.lo_we = 1'b0; bus.hi_we = 1'b1; bus.wdata = 32'hCAFE_0001;
    checks++; if (bus.lo !== 32'h1234) begin errors++; $display("FAIL mtlo got=%h exp=00001234", bus.lo); end
    @(negedge clk); bus.hi_we = 1'b0;
    checks++; if (bus.hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi got=%h exp=cafe0001", bus.hi); end
    a = $urandom | 32'h0100_0000; b = $urandom | 32'h0100_0000; exp = model(a, b, 1'b0);
    run_mult(a, b, 1'b0, 1'b0, 5, 2, lat, bn, dn, hold);
    checks++; if (bus.hi !== exp[63:32]) begin errors++; $display("FAIL mthi_busy hi got=%h exp=%h", bus.hi, exp[63:32]); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL mthi_busy hold got=%b exp=1", hold); end
    a = $urandom; b = $urandom; exp = model(a, b, 1'b1);
    run_mult(a, b, 1'b1, 1'b1, 0, 0, lat, bn, dn, hold);
    checks++; if (bus.lo !== exp[31:0]) begin errors++; $display("FAIL start_mtlo lo got=%h exp=%h", bus.lo, exp[31:0]); end
    checks++; if (bus.hi !== exp[63:32]) begin errors++; $display("FAIL start_mtlo hi got=%h exp=%h", bus.hi, exp[63:32]); end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'h0123_4567; bus.op_b = 32'h89AB;
    @(negedge clk); bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo got=%h exp=0", {bus.hi, bus.lo}); end
    #1 rst = 1'b0;
    chk_mult("after_reset_2x2", 32'd2, 32'd2, 1'b0);
  endtask
  initial begin
    test_reset();
    test_multu_basic();
    test_mult_signed();
    test_random();
    test_start_while_busy();
    test_mthi_mtlo();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Sequential shift-add multiplier that owns the HI/LO register pair for MULT/MULTU.
- Sits directly downstream of the multiply-detection stall FSM. When that FSM enters its stall state, the datapath pulses start with rs/rt.
- The unit iterates one bit per cycle and writes the 64-bit product into HI/LO. MFHI/MFLO read HI/LO combinationally; MTHI/MTLO write them.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a multiply; honoured only in IDLE
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- op_a  input  WIDTH  multiplicand (rs); sampled with start
- op_b  input  WIDTH  multiplier (rt); sampled with start
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  high while a multiply is in progress (state != IDLE)
- done  output  1  one-cycle pulse; HI/LO hold the new product in the same cycle
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, hi=0, lo=0, done=0, busy=0. All internal accumulator, operand and counter registers are cleared. An aborted multiply leaves no trace.
- States: IDLE, RUN, FIX. done is a registered output.
- IDLE, start=1 at edge E0:
  - Latch neg = is_signed & (op_a[W-1] ^ op_b[W-1]).
  - Latch magnitudes |op_a| and |op_b| (plain values when is_signed=0).
  - Clear the 2W-bit accumulator; cnt=0; go to RUN.
- RUN, edges E1..EW:
  - If multiplier LSB=1, add the multiplicand into the upper half of the accumulator, carry kept.
  - Shift the accumulator right by 1; shift the multiplier right by 1; cnt++.
  - At the edge where cnt reaches WIDTH-1→WIDTH (edge EW), go to FIX.
- FIX, edge E(W+1):
  - {hi,lo} = neg ? two's-complement negate of the accumulator : accumulator.
  - done=1; go to IDLE.
- done is high exactly for the cycle after E(W+1), then returns to 0.
- Latency and busy timing:
  - busy is high W+1 cycles (after E0 through E(W+1)).
  - Result is visible WIDTH+1 edges after the start edge: 33 edges at W=32.
  - The upstream stall of 32+ cycles covers this; the pipeline must not issue MFHI/MFLO before done.
- Edge cases:
  - Magnitude of the most negative value (0x80000000) is 0x80000000 unsigned; the 2W-bit path handles it without overflow.
  - start while busy: ignored; the in-flight operation continues unaffected.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata on the edge.
  - While busy (RUN/FIX), writes are ignored.
  - If start and hi_we/lo_we fall on the same IDLE edge, both take effect; the later multiply result overwrites HI/LO.
- hi/lo hold their old values throughout RUN; there is no partial update.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'b00, RUN=2'b01, FIX=2'b10.
  - Funct codes FUNCT_MULT=6'd24 and FUNCT_MULTU=6'd25, also used by the detection FSM.
  - WIDTH default.
- Optional sub-module: mult_shift_add_step, the combinational single-iteration add/shift over {acc, multiplier}. Keeps the FSM file to control and HI/LO only.

Test Plan:
- MULTU 3 × 5: start with is_signed=0 → busy high 33 cycles; done pulse; hi=0x00000000, lo=0x0000000F.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after the start edge.
- MULT −2 × 7 (0xFFFFFFFE, 0x00000007) → hi=0xFFFFFFFF, lo=0xFFFFFFF2. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- Second start pulse at cycle 10 of a 6×7 op, with different operands → ignored; result hi=0, lo=42; a single done pulse.
- Async reset asserted at cycle 15 of a multiply → hi=lo=0, busy=0 immediately. A fresh 2×2 then yields lo=4 with normal latency.
- MTLO 0x1234 in IDLE → lo=0x1234. MTHI while busy → ignored, HI equals the product. start and lo_we on the same edge → final lo equals the product.
